// File: rtl/bf_config_writer_pkg.sv
// Shared types and constants for the config-RAM writer (bf_config_writer).
package bf_config_writer_pkg;

    localparam int unsigned STAGE_SEL_W = 8;
    localparam int unsigned ERR_CNT_W   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StDone
    } wr_state_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bf_cfg_wr_pipe_point.sv
// One point of the beat delivery chain: registered when PIPED is set, otherwise a wire.
module bf_cfg_wr_pipe_point
    import bf_config_writer_pkg::*;
#(
    parameter bit          PIPED      = 1'b1,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CFG_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [STAGE_SEL_W-1:0] i_stage,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [CFG_WIDTH-1:0]   i_data,
    output logic                   o_valid,
    output logic [STAGE_SEL_W-1:0] o_stage,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic [CFG_WIDTH-1:0]   o_data
);

    logic                   r_valid;
    logic [STAGE_SEL_W-1:0] r_stage;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [CFG_WIDTH-1:0]   r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_stage <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_stage <= i_stage;
                r_addr  <= i_addr;
                r_data  <= i_data;
            end
        end
    end

    // Unregistered points leave the flops unloaded; synthesis removes them.
    assign o_valid = PIPED ? r_valid : i_valid;
    assign o_stage = PIPED ? r_stage : i_stage;
    assign o_addr  = PIPED ? r_addr  : i_addr;
    assign o_data  = PIPED ? r_data  : i_data;

endmodule

// File: rtl/bf_config_writer.sv
// Streams config beats into STAGE_NUM per-stage RAMs through a skewed delivery chain.
// Optional range checking with error counter: define BF_CFG_WR_RANGE_CHECK_EN.
module bf_config_writer
    import bf_config_writer_pkg::*;
#(
    parameter int unsigned          STAGE_NUM  = 4,
    parameter int unsigned          CFG_WIDTH  = 16,
    parameter int unsigned          CFG_DEPTH  = 64,
    parameter int unsigned          ADDR_WIDTH = 6,
    parameter logic [STAGE_NUM-1:0] PIPED_MASK = STAGE_NUM'(4'b0101)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [15:0]                     beat_num,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [STAGE_SEL_W-1:0]          s_stage,
    input  logic [ADDR_WIDTH-1:0]           s_addr,
    input  logic [CFG_WIDTH-1:0]            s_data,
    output logic [STAGE_NUM-1:0]            cfg_wr_en,
    output logic [STAGE_NUM*ADDR_WIDTH-1:0] cfg_waddr,
    output logic [STAGE_NUM*CFG_WIDTH-1:0]  cfg_wdata,
    output logic                            busy,
    output logic                            done,
    output logic [ERR_CNT_W-1:0]            err_cnt
);

    localparam int unsigned DrainCycles = 1 + popcount(32'(PIPED_MASK));
    localparam logic [7:0]  DrainLoad   = 8'(DrainCycles - 1);

    if (CFG_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("CFG_DEPTH does not fit in ADDR_WIDTH");
    end

    wr_state_e   r_state, w_state_d;
    logic [15:0] r_remain, w_remain_d;
    logic [7:0]  r_drain_cnt, w_drain_d;
    logic        w_accept;
    logic        w_in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_remain    <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_remain    <= w_remain_d;
            r_drain_cnt <= w_drain_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_remain_d = r_remain;
        w_drain_d  = r_drain_cnt;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_remain_d = beat_num;
                    if (beat_num == 16'd0) begin
                        w_state_d = StDrain;
                        w_drain_d = DrainLoad;
                    end else begin
                        w_state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    w_remain_d = r_remain - 16'd1;
                    if (r_remain == 16'd1) begin
                        w_state_d = StDrain;
                        w_drain_d = DrainLoad;
                    end
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (r_drain_cnt == 8'd0) begin
                    w_state_d = StDone;
                end else begin
                    w_drain_d = r_drain_cnt - 8'd1;
                end
            end
            StDone: begin
                done      = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_accept = s_valid & s_ready;

`ifdef BF_CFG_WR_RANGE_CHECK_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_in_range = (s_stage < STAGE_SEL_W'(STAGE_NUM)) && (32'(s_addr) < CFG_DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    // Out-of-range stages simply match no RAM further down.
    assign w_in_range = 1'b1;
    assign err_cnt    = '0;
`endif

    // Index 0 is the input register; index p+1 is the output of point p.
    logic [STAGE_NUM:0]     w_pt_valid;
    logic [STAGE_SEL_W-1:0] w_pt_stage [STAGE_NUM+1];
    logic [ADDR_WIDTH-1:0]  w_pt_addr  [STAGE_NUM+1];
    logic [CFG_WIDTH-1:0]   w_pt_data  [STAGE_NUM+1];

    logic                   r_in_valid;
    logic [STAGE_SEL_W-1:0] r_in_stage;
    logic [ADDR_WIDTH-1:0]  r_in_addr;
    logic [CFG_WIDTH-1:0]   r_in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_valid <= 1'b0;
            r_in_stage <= '0;
            r_in_addr  <= '0;
            r_in_data  <= '0;
        end else begin
            r_in_valid <= w_accept & w_in_range;
            if (w_accept) begin
                r_in_stage <= s_stage;
                r_in_addr  <= s_addr;
                r_in_data  <= s_data;
            end
        end
    end

    assign w_pt_valid[0] = r_in_valid;
    assign w_pt_stage[0] = r_in_stage;
    assign w_pt_addr[0]  = r_in_addr;
    assign w_pt_data[0]  = r_in_data;

    for (genvar p = 0; p < STAGE_NUM; p++) begin : g_point
        bf_cfg_wr_pipe_point #(
            .PIPED      (PIPED_MASK[p]),
            .ADDR_WIDTH (ADDR_WIDTH),
            .CFG_WIDTH  (CFG_WIDTH)
        ) u_point (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_pt_valid[p]),
            .i_stage (w_pt_stage[p]),
            .i_addr  (w_pt_addr[p]),
            .i_data  (w_pt_data[p]),
            .o_valid (w_pt_valid[p+1]),
            .o_stage (w_pt_stage[p+1]),
            .o_addr  (w_pt_addr[p+1]),
            .o_data  (w_pt_data[p+1])
        );
    end

    // RAM j taps point STAGE_NUM-1-j, i.e. chain index STAGE_NUM-j.
    for (genvar j = 0; j < STAGE_NUM; j++) begin : g_ram
        logic [ADDR_WIDTH-1:0] r_addr_hold;
        logic [CFG_WIDTH-1:0]  r_data_hold;
        logic                  w_wr;

        assign w_wr = w_pt_valid[STAGE_NUM-j] && (w_pt_stage[STAGE_NUM-j] == STAGE_SEL_W'(j));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_addr_hold <= '0;
                r_data_hold <= '0;
            end else if (w_wr) begin
                r_addr_hold <= w_pt_addr[STAGE_NUM-j];
                r_data_hold <= w_pt_data[STAGE_NUM-j];
            end
        end

        assign cfg_wr_en[j] = w_wr;
        assign cfg_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] = w_wr ? w_pt_addr[STAGE_NUM-j] : r_addr_hold;
        assign cfg_wdata[j*CFG_WIDTH +: CFG_WIDTH]   = w_wr ? w_pt_data[STAGE_NUM-j] : r_data_hold;
    end

endmodule
